rca_serial_ctrl: RTL



---
 rtl/rca_pkg.sv | 17 +
 rtl/rca_slice4.sv | 22 ++
 rtl/rca_serial_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Slice width and nibble-count helper live here.
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    function automatic int nib_of(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/rca_slice4.sv
// Combinational 4-bit ripple-carry slice.
// Four full adders chained LSB to MSB.
module rca_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[4];

endmodule

// File: rtl/rca_serial_ctrl.sv
// Nibble-serial adder sequencer driving one shared 4-bit slice.
// Define RCA_SERIAL_SUB_EN to add the sub port (a - b).
module rca_serial_ctrl
    import rca_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef RCA_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             busy
);

    localparam int NIB = nib_of(WIDTH);
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("rca_serial_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t            state, state_n;
    logic [WIDTH-1:0]  a_r, b_r;
    logic              carry;
    logic [IW-1:0]     idx;
    logic [WIDTH:0]    sum_r;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic [3:0]        sa, sb, ss;
    logic              sco;

`ifdef RCA_SERIAL_SUB_EN
    // Subtract as a + ~b + 1; carry-out of 1 means no borrow
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign sa = a_r[NIBBLE_W*idx +: NIBBLE_W];
    assign sb = b_r[NIBBLE_W*idx +: NIBBLE_W];

    rca_slice4 u_slice (
        .a  (sa),
        .b  (sb),
        .ci (carry),
        .s  (ss),
        .co (sco)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST) state_n = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum_r <= '0;
        end else if (state == IDLE && in_valid) begin
            a_r   <= a;
            b_r   <= b_eff;
            carry <= cin_eff;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_r[NIBBLE_W*idx +: NIBBLE_W] <= ss;
            carry <= sco;
            idx   <= idx + 1'b1;
            if (idx == LAST) sum_r[WIDTH] <= sco;
        end
    end

    assign sum = sum_r;

endmodule
